// File: rtl/c17_stim_pkg.sv
// +--------------------------------------------------------------------------+
// | c17_stim_pkg : shared constants for the c17 stimulus generator           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package c17_stim_pkg;

    localparam int PAT_W = 5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // x^5 + x^3 + 1, shifted left with feedback entering at bit 0
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;
    localparam logic [PAT_W-1:0] SEED_SUBST = 5'b00001;

    localparam int TEST_MSB = 4;
    localparam int TEST_LSB = 2;
    localparam int NX2_BIT  = 1;
    localparam int NX6_BIT  = 0;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] p);
        return {p[PAT_W-2:0], p[LFSR_TAP_HI] ^ p[LFSR_TAP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/c17_lfsr5.sv
// +--------------------------------------------------------------------------+
// | c17_lfsr5 : 5-bit pattern register, binary count or LFSR advance         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module c17_lfsr5
    import c17_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAT_W-1:0] seed,
    input  logic             mode_cnt,
    input  logic             adv,
    input  logic             force_zero,
    output logic [PAT_W-1:0] pat
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             cnt_q, cnt_d;

    always_comb begin
        pat_d = pat_q;
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = mode_cnt;
            // The all-zero state locks up the LFSR, so it is never used as a seed.
            if (!mode_cnt && (seed == '0)) begin
                pat_d = SEED_SUBST;
            end else begin
                pat_d = seed;
            end
        end else if (adv) begin
            if (cnt_q) begin
                pat_d = pat_q + 1'b1;
            end else if (force_zero) begin
                pat_d = '0;
            end else begin
                pat_d = lfsr_next(pat_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            cnt_q <= 1'b0;
        end else begin
            pat_q <= pat_d;
            cnt_q <= cnt_d;
        end
    end

    assign pat = pat_q;

endmodule

`default_nettype wire

// File: rtl/c17_stim_gen.sv
// +--------------------------------------------------------------------------+
// | c17_stim_gen : valid/ready stimulus generator for the c17 NAND2 netlist  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module c17_stim_gen
    import c17_stim_pkg::*;
#(
    parameter int NUM_PAT      = 32,
    parameter int INCLUDE_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [PAT_W-1:0] seed,
    input  logic             pat_ready,
    output logic             pat_valid,
    output logic [2:0]       stim_test,
    output logic             stim_nx2,
    output logic             stim_nx6,
    output logic [PAT_W-1:0] pat_idx,
    output logic             pat_last,
    output logic             busy,
    output logic             done
);

    localparam logic [PAT_W-1:0] LAST_IDX  = PAT_W'(NUM_PAT - 1);
    localparam logic [PAT_W-1:0] ZERO_IDX  = PAT_W'(30);
    localparam bit               ZERO_TAIL = (INCLUDE_ZERO != 0) && (NUM_PAT == 32);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] idx_q, idx_d;
    logic             load;
    logic             adv;
    logic             force_zero;
    logic [PAT_W-1:0] pat;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (pat_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        adv   = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything; the pattern register keeps its value.
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            load    = 1'b0;
            adv     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Advancing into index 31 of a full LFSR run yields the one state the LFSR cannot.
    assign force_zero = ZERO_TAIL && (idx_q == ZERO_IDX);

    c17_lfsr5 u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .seed       (seed),
        .mode_cnt   (mode),
        .adv        (adv),
        .force_zero (force_zero),
        .pat        (pat)
    );

    assign pat_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pat_last  = (state_q == ST_RUN) && (idx_q == LAST_IDX);
    assign pat_idx   = idx_q;
    assign stim_test = pat[TEST_MSB:TEST_LSB];
    assign stim_nx2  = pat[NX2_BIT];
    assign stim_nx6  = pat[NX6_BIT];

endmodule

`default_nettype wire
